// File: rtl/dmi_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dmi_boot_sequencer
// Description : Hardware debug boot flow. Masters the DMI request/response
//               channel to activate the DM, halt one hart, wait for an
//               external memory loader, write the boot PC into DPC through
//               an abstract command and resume the hart.
// Ports       : clk_i / rst_i            clock, async active-high reset
//               start_i                  pulse, starts (or restarts) the flow
//               load_done_i              level, external loader finished
//               dmi_req_*                DMI request channel (master side)
//               dmi_resp_*               DMI response channel (master side)
//               busy_o / halted_o        sequence running / hart parked
//               done_o / error_o         sticky completion / abort flags
//               err_code_o               abort cause, valid while error_o
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_boot_sequencer #(
    parameter logic [31:0] BOOT_ADDR  = 32'h8000_0080,
    parameter logic [9:0]  HART_SEL   = 10'd0,
    parameter logic [2:0]  AARSIZE    = 3'd3,
    parameter logic [15:0] POLL_LIMIT = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        load_done_i,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_addr_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i,
    output logic        busy_o,
    output logic        halted_o,
    output logic        done_o,
    output logic        error_o,
    output logic [2:0]  err_code_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ACTIVE    = 4'd1,
        S_HALT      = 4'd2,
        S_POLL_HALT = 4'd3,
        S_WAIT_LOAD = 4'd4,
        S_DATA0     = 4'd5,
        S_DATA1     = 4'd6,
        S_CMD       = 4'd7,
        S_POLL_ABS  = 4'd8,
        S_RESUME    = 4'd9,
        S_POLL_RES  = 4'd10,
        S_CLEAR     = 4'd11,
        S_DONE      = 4'd12,
        S_ERROR     = 4'd13
    } state_t;

    localparam logic [31:0] c_hartsel   = {6'd0, HART_SEL, 16'd0};
    // Access Register: transfer=1, write=1, regno=DPC (0x7B1)
    localparam logic [31:0] c_cmd_word  = {8'h00, 1'b0, AARSIZE, 1'b0, 1'b0,
                                           1'b1, 1'b1, 16'h07B1};
    localparam logic [1:0]  c_op_rd     = 2'd1;
    localparam logic [1:0]  c_op_wr     = 2'd2;
    localparam logic [1:0]  c_resp_ok   = 2'd0;
    localparam logic [1:0]  c_resp_busy = 2'd3;
    localparam logic        c_ph_req    = 1'b0;
    localparam logic        c_ph_rsp    = 1'b1;
    localparam logic [2:0]  c_err_resp  = 3'd1;
    localparam logic [2:0]  c_err_halt  = 3'd2;
    localparam logic [2:0]  c_err_cmd   = 3'd3;
    localparam logic [2:0]  c_err_abs   = 3'd4;
    localparam logic [2:0]  c_err_res   = 3'd5;

    // ------------------------------------------------------------------
    // Per-step request payload
    // ------------------------------------------------------------------
    function automatic logic is_dmi_step(input state_t s);
        return !(s inside {S_IDLE, S_WAIT_LOAD, S_DONE, S_ERROR});
    endfunction

    function automatic logic [6:0] step_addr(input state_t s);
        case (s)
            S_ACTIVE, S_HALT, S_RESUME, S_CLEAR: return 7'h10;
            S_POLL_HALT, S_POLL_RES:             return 7'h11;
            S_DATA0:                             return 7'h04;
            S_DATA1:                             return 7'h05;
            S_CMD:                               return 7'h17;
            S_POLL_ABS:                          return 7'h16;
            default:                             return 7'h00;
        endcase
    endfunction

    function automatic logic [1:0] step_op(input state_t s);
        case (s)
            S_POLL_HALT, S_POLL_ABS, S_POLL_RES: return c_op_rd;
            S_ACTIVE, S_HALT, S_DATA0, S_DATA1,
            S_CMD, S_RESUME, S_CLEAR:            return c_op_wr;
            default:                             return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] step_data(input state_t s);
        case (s)
            S_ACTIVE: return 32'h0000_0001;
            S_HALT:   return 32'h8000_0001 | c_hartsel;
            S_DATA0:  return BOOT_ADDR;
            S_CMD:    return c_cmd_word;
            S_RESUME: return 32'h4000_0001 | c_hartsel;
            S_CLEAR:  return 32'h0000_0001 | c_hartsel;
            default:  return 32'h0000_0000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_phase;
    logic [15:0] r_poll_cnt;
    logic        r_req_valid;
    logic [6:0]  r_req_addr;
    logic [1:0]  r_req_op;
    logic [31:0] r_req_data;
    logic        r_resp_ready;
    logic        r_busy;
    logic        r_halted;
    logic        r_done;
    logic        r_error;
    logic [2:0]  r_err_code;

    state_t      w_nxt_state;
    logic        w_nxt_phase;
    logic [2:0]  w_nxt_err;
    logic        w_poll_inc;
    logic        w_poll_last;
    logic        w_unused_data;

    // Only a handful of status bits are interpreted.
    assign w_unused_data = ^dmi_resp_data_i;

    // The read now completing is the POLL_LIMIT-th one of this phase.
    assign w_poll_last = ({1'b0, r_poll_cnt} + 17'd1) >= {1'b0, POLL_LIMIT};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_err   = r_err_code;
        w_poll_inc  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    w_nxt_state = S_ACTIVE;
                    w_nxt_phase = c_ph_req;
                    w_nxt_err   = 3'd0;
                end
            end
            S_WAIT_LOAD: begin
                if (load_done_i) begin
                    w_nxt_state = S_DATA0;
                end
            end
            default: begin
                if (r_phase == c_ph_req) begin
                    if (dmi_req_ready_i) begin
                        w_nxt_phase = c_ph_rsp;
                    end
                end else if (dmi_resp_valid_i) begin
                    w_nxt_phase = c_ph_req;
                    if (dmi_resp_resp_i == c_resp_busy) begin
                        // Same state, same payload: the request is reissued.
                        w_nxt_state = r_state;
                    end else if (dmi_resp_resp_i != c_resp_ok) begin
                        w_nxt_state = S_ERROR;
                        w_nxt_err   = c_err_resp;
                    end else begin
                        case (r_state)
                            S_ACTIVE: w_nxt_state = S_HALT;
                            S_HALT:   w_nxt_state = S_POLL_HALT;
                            S_POLL_HALT: begin
                                if (dmi_resp_data_i[9]) begin
                                    w_nxt_state = S_WAIT_LOAD;
                                end else if (w_poll_last) begin
                                    w_nxt_state = S_ERROR;
                                    w_nxt_err   = c_err_halt;
                                end else begin
                                    w_poll_inc = 1'b1;
                                end
                            end
                            S_DATA0:  w_nxt_state = (AARSIZE == 3'd3) ? S_DATA1 : S_CMD;
                            S_DATA1:  w_nxt_state = S_CMD;
                            S_CMD:    w_nxt_state = S_POLL_ABS;
                            S_POLL_ABS: begin
                                if (!dmi_resp_data_i[12]) begin
                                    if (dmi_resp_data_i[10:8] != 3'd0) begin
                                        w_nxt_state = S_ERROR;
                                        w_nxt_err   = c_err_cmd;
                                    end else begin
                                        w_nxt_state = S_RESUME;
                                    end
                                end else if (w_poll_last) begin
                                    w_nxt_state = S_ERROR;
                                    w_nxt_err   = c_err_abs;
                                end else begin
                                    w_poll_inc = 1'b1;
                                end
                            end
                            S_RESUME: w_nxt_state = S_POLL_RES;
                            S_POLL_RES: begin
                                if (dmi_resp_data_i[17]) begin
                                    w_nxt_state = S_CLEAR;
                                end else if (w_poll_last) begin
                                    w_nxt_state = S_ERROR;
                                    w_nxt_err   = c_err_res;
                                end else begin
                                    w_poll_inc = 1'b1;
                                end
                            end
                            S_CLEAR:  w_nxt_state = S_DONE;
                            default:  w_nxt_state = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // All outputs are registered from the next-state decode so they change
    // together with the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_phase      <= c_ph_req;
            r_poll_cnt   <= 16'd0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= 7'd0;
            r_req_op     <= 2'd0;
            r_req_data   <= 32'd0;
            r_resp_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 3'd0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            if (w_nxt_state != r_state) begin
                r_poll_cnt <= 16'd0;
            end else if (w_poll_inc) begin
                r_poll_cnt <= r_poll_cnt + 16'd1;
            end
            r_req_valid  <= is_dmi_step(w_nxt_state) && (w_nxt_phase == c_ph_req);
            r_resp_ready <= is_dmi_step(w_nxt_state) && (w_nxt_phase == c_ph_rsp);
            r_req_addr   <= step_addr(w_nxt_state);
            r_req_op     <= step_op(w_nxt_state);
            r_req_data   <= step_data(w_nxt_state);
            r_busy       <= !(w_nxt_state inside {S_IDLE, S_DONE, S_ERROR});
            r_halted     <= (w_nxt_state == S_WAIT_LOAD);
            r_done       <= (w_nxt_state == S_DONE);
            r_error      <= (w_nxt_state == S_ERROR);
            r_err_code   <= (w_nxt_state == S_ERROR) ? w_nxt_err : 3'd0;
        end
    end

    assign dmi_req_valid_o  = r_req_valid;
    assign dmi_req_addr_o   = r_req_addr;
    assign dmi_req_op_o     = r_req_op;
    assign dmi_req_data_o   = r_req_data;
    assign dmi_resp_ready_o = r_resp_ready;
    assign busy_o           = r_busy;
    assign halted_o         = r_halted;
    assign done_o           = r_done;
    assign error_o          = r_error;
    assign err_code_o       = r_err_code;

endmodule
`default_nettype wire
